// File: rtl/ram_bist_ctrl_if.sv
// RAM write/read port bundle between the BIST initiator and the 16x8 synchronous RAM.
interface ram_bist_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              wr_enb;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_enb;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/ram_bist_ctrl.sv
// March BIST initiator: write P, read/compare P, write ~P, read/compare ~P descending.
// Reports pass/fail, a saturating mismatch count and the first failing access.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for start, status held
// S_WR0    | write P(a), address ascending
// S_RD0    | read, expect P(a), address ascending
// S_WR1    | write ~P(a), address ascending
// S_RD1    | read, expect ~P(a), address descending
// S_DRAIN  | last read compare, no RAM access
// S_DONE   | done pulse, pass resolved
module ram_bist_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    ram_bist_ctrl_if.master   ram
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR0   = 3'd1;
    localparam logic [2:0] S_RD0   = 3'd2;
    localparam logic [2:0] S_WR1   = 3'd3;
    localparam logic [2:0] S_RD1   = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    function automatic logic [DATA_W-1:0] pat(input logic [1:0] s, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] p;
        p = '0;
        case (s)
            2'd0: for (int i = 0; i < DATA_W; i++) p[i] = a[0] ~^ i[0];
            2'd1: p = DATA_W'(a);
            2'd2: p = '0;
            default: p = '1;
        endcase
        return p;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        sel_q, sel_d;
    logic              wr_enb_q, wr_enb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_enb_q, rd_enb_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_got_q, fail_got_d;
    logic [DATA_W-1:0] pat_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR0;
                    addr_d  = '0;
                    sel_d   = pattern_sel;
                end
            end
            S_WR0, S_RD0: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = (state_q == S_WR0) ? S_RD0 : S_WR1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_WR1: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_RD1;
                    addr_d  = ADDR_LAST;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_RD1: begin
                if (addr_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q - ADDR_ONE;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Port and status outputs are registered from the next state so they line up with it.
    always_comb begin
        pat_d     = pat(sel_d, addr_d);
        wr_enb_d  = (state_d == S_WR0) || (state_d == S_WR1);
        rd_enb_d  = (state_d == S_RD0) || (state_d == S_RD1);
        wr_addr_d = wr_enb_d ? addr_d : '0;
        rd_addr_d = rd_enb_d ? addr_d : '0;
        wr_data_d = (state_d == S_WR0) ? pat_d : (state_d == S_WR1) ? ~pat_d : '0;
        exp_d     = (state_d == S_RD0) ? pat_d : (state_d == S_RD1) ? ~pat_d : '0;
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);

        cmp_vld_d  = rd_enb_q;
        cmp_addr_d = rd_addr_q;
        cmp_exp_d  = exp_q;

        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        pass_d      = pass_q;
        if (state_q == S_IDLE && start) begin
            err_cnt_d   = '0;
            fail_addr_d = '0;
            fail_exp_d  = '0;
            fail_got_d  = '0;
            pass_d      = 1'b0;
        end else if (cmp_vld_q && (ram.rd_data != cmp_exp_q)) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_ONE;
            if (err_cnt_q == '0) begin
                fail_addr_d = cmp_addr_q;
                fail_exp_d  = cmp_exp_q;
                fail_got_d  = ram.rd_data;
            end
        end
        // The final compare lands in DRAIN, so pass must see this cycle's count.
        if (state_d == S_DONE) pass_d = (err_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            sel_q       <= '0;
            wr_enb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_enb_q    <= 1'b0;
            rd_addr_q   <= '0;
            exp_q       <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_exp_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            wr_enb_q    <= wr_enb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_enb_q    <= rd_enb_d;
            rd_addr_q   <= rd_addr_d;
            exp_q       <= exp_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_exp_q   <= cmp_exp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
        end
    end

    assign ram.wr_enb  = wr_enb_q;
    assign ram.wr_addr = wr_addr_q;
    assign ram.wr_data = wr_data_q;
    assign ram.rd_enb  = rd_enb_q;
    assign ram.rd_addr = rd_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_cnt     = err_cnt_q;
    assign fail_addr   = fail_addr_q;
    assign fail_exp    = fail_exp_q;
    assign fail_got    = fail_got_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a 16x8 RAM model that can inject per-address read faults.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] pattern_sel;
    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic [3:0] fail_addr;
    logic [7:0] fail_exp, fail_got;

    ram_bist_ctrl_if #(.ADDR_W(4), .DATA_W(8)) ram_if ();

    ram_bist_ctrl #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern_sel(pattern_sel),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
        .ram(ram_if)
    );

    always #5 clk = ~clk;

    logic [7:0] mem   [0:15];
    logic [7:0] and_m [0:15];
    logic [7:0] or_m  [0:15];

    always @(posedge clk) begin
        if (ram_if.wr_enb) mem[ram_if.wr_addr] <= ram_if.wr_data;
        if (ram_if.rd_enb)
            ram_if.rd_data <= (mem[ram_if.rd_addr] & and_m[ram_if.rd_addr]) | or_m[ram_if.rd_addr];
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    logic       busy_l [0:199], done_l [0:199], pass_l [0:199], wen_l [0:199], ren_l [0:199];
    logic [7:0] err_l [0:199], fexp_l [0:199], fgot_l [0:199], wdata_l [0:199];
    logic [3:0] faddr_l [0:199], waddr_l [0:199], raddr_l [0:199];
    logic       rb_busy, rb_ren;
    logic [7:0] rb_err;

    task automatic rec(input int k);
        busy_l[k]  = busy;          done_l[k]  = done;         pass_l[k] = pass;
        err_l[k]   = err_cnt;       faddr_l[k] = fail_addr;
        fexp_l[k]  = fail_exp;      fgot_l[k]  = fail_got;
        wen_l[k]   = ram_if.wr_enb; waddr_l[k] = ram_if.wr_addr; wdata_l[k] = ram_if.wr_data;
        ren_l[k]   = ram_if.rd_enb; raddr_l[k] = ram_if.rd_addr;
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 16; i++) begin
            and_m[i] = 8'hFF;
            or_m[i]  = 8'h00;
        end
    endtask

    // Cycle k is the k-th clock period after the edge that samples start.
    task automatic run(input logic [1:0] sel, input int n, input int restart_cyc,
                       input int rst_cyc, input bit hold);
        @(negedge clk);
        start = 1'b1;
        pattern_sel = sel;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) start = 1'b0;
            rec(k);
            if (k == restart_cyc) start = 1'b1;
            if (k == restart_cyc + 1) start = 1'b0;
            if (k == rst_cyc) begin
                rst = 1'b0;
                #1;
                rb_busy = busy;
                rb_ren  = ram_if.rd_enb;
                rb_err  = err_cnt;
            end
            if (k == rst_cyc + 3) rst = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic scan(input int lo, input int hi, output int b_first, output int b_last,
                        output int d_cnt, output int d_first, output int ovl, output int act);
        b_first = -1; b_last = -1; d_cnt = 0; d_first = -1; ovl = 0; act = 0;
        for (int k = lo; k <= hi; k++) begin
            if (busy_l[k]) begin
                if (b_first < 0) b_first = k;
                b_last = k;
            end
            if (done_l[k]) begin
                d_cnt++;
                if (d_first < 0) d_first = k;
            end
            if (wen_l[k] && ren_l[k]) ovl++;
            if (wen_l[k] || ren_l[k]) act++;
        end
    endtask

    int b_first, b_last, d_cnt, d_first, ovl, act, seq_ok;

    initial begin
        rst = 1'b0;
        start = 1'b0;
        pattern_sel = 2'd0;
        clear_faults();
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, pass, ram_if.wr_enb, ram_if.rd_enb, err_cnt,
                                fail_addr, fail_exp, fail_got},
              32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Fault-free, checkerboard pattern
        run(2'd0, 70, -1, -1, 1'b0);
        scan(1, 70, b_first, b_last, d_cnt, d_first, ovl, act);
        check("sel0_wr0_addr3", {waddr_l[4], wdata_l[4]}, {4'd3, 8'hAA});
        check("sel0_wr1_addr3", {waddr_l[36], wdata_l[36]}, {4'd3, 8'h55});
        check("sel0_busy_first", b_first, 1);
        check("sel0_busy_last", b_last, 65);
        check("sel0_done_cycle", d_first, 66);
        check("sel0_done_count", d_cnt, 1);
        check("sel0_busy_at_done", busy_l[66], 1'b0);
        check("sel0_pass", pass_l[66], 1'b1);
        check("sel0_err_cnt", err_l[66], 8'd0);

        // Bit0 forced high at addr 5, all-zeros pattern
        clear_faults();
        or_m[5] = 8'h01;
        run(2'd2, 70, -1, -1, 1'b0);
        check("pass_cleared_on_start", pass_l[1], 1'b0);
        check("bit0_err_cnt", err_l[66], 8'd1);
        check("bit0_fail_addr", faddr_l[66], 4'd5);
        check("bit0_fail_exp", fexp_l[66], 8'h00);
        check("bit0_fail_got", fgot_l[66], 8'h01);
        check("bit0_pass", pass_l[66], 1'b0);

        // Addrs 9 and 2 stuck at zero, all-ones pattern
        clear_faults();
        and_m[9] = 8'h00;
        and_m[2] = 8'h00;
        run(2'd3, 70, -1, -1, 1'b0);
        check("stuck_fail_addr", faddr_l[66], 4'd2);
        check("stuck_fail_exp", fexp_l[66], 8'hFF);
        check("stuck_fail_got", fgot_l[66], 8'h00);
        check("stuck_err_after_rd0", err_l[48], 8'd2);
        check("stuck_err_final", err_l[66], 8'd2);
        check("stuck_err_held", err_l[70], 8'd2);
        check("stuck_pass", pass_l[66], 1'b0);

        // Second start mid-run ignored; new run clears status left by the last one
        clear_faults();
        run(2'd0, 150, 30, -1, 1'b0);
        scan(1, 150, b_first, b_last, d_cnt, d_first, ovl, act);
        check("restart_err_clear", err_l[1], 8'd0);
        check("restart_fail_clear", {faddr_l[1], fexp_l[1], fgot_l[1]}, 32'h0);
        check("restart_done_count", d_cnt, 1);
        check("restart_done_cycle", d_first, 66);
        check("restart_busy_last", b_last, 65);

        // Address-valued pattern, address sequences and write data
        run(2'd1, 70, -1, -1, 1'b0);
        scan(1, 70, b_first, b_last, d_cnt, d_first, ovl, act);
        seq_ok = 0;
        for (int k = 17; k <= 32; k++) if (ren_l[k] && int'(raddr_l[k]) == k - 17) seq_ok++;
        for (int k = 49; k <= 64; k++) if (ren_l[k] && int'(raddr_l[k]) == 64 - k) seq_ok++;
        check("sel1_rd_addr_seq", seq_ok, 32);
        check("sel1_wr0_addr7", {waddr_l[8], wdata_l[8]}, {4'd7, 8'h07});
        check("sel1_wr1_addr7", {waddr_l[40], wdata_l[40]}, {4'd7, 8'hF8});
        check("sel1_no_overlap", ovl, 0);
        check("sel1_port_idle_after", {wen_l[65], ren_l[65], wen_l[66], ren_l[66]}, 4'h0);
        check("sel1_pass", pass_l[66], 1'b1);

        // start held high relaunches right after DONE
        run(2'd0, 70, -1, -1, 1'b1);
        check("hold_done", done_l[66], 1'b1);
        check("hold_idle_gap", busy_l[67], 1'b0);
        check("hold_relaunch", {busy_l[68], wen_l[68]}, 2'b11);
        repeat (80) @(negedge clk);

        // Reset mid RD0 with addr 0 stuck so err_cnt is already nonzero
        clear_faults();
        and_m[0] = 8'h00;
        run(2'd3, 90, -1, 20, 1'b0);
        scan(1, 90, b_first, b_last, d_cnt, d_first, ovl, act);
        check("rst_pre_state", {ren_l[20], busy_l[20], err_l[20]}, {1'b1, 1'b1, 8'd1});
        check("rst_async_clear", {rb_busy, rb_ren, rb_err}, 10'h0);
        check("rst_no_done", d_cnt, 0);
        scan(21, 90, b_first, b_last, d_cnt, d_first, ovl, act);
        check("rst_port_idle_after", act, 0);
        check("rst_busy_idle_after", b_first, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
